// File: rtl/mem_access_stage.sv
// MEM stage: sized loads/stores over a variable-latency req/ready bus,
// with upstream stall, timeout abort and misalignment drop.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   *_in               EX/MEM register contents (instruction in MEM)
//   dmem_*             data memory request/response
//   stall_out          freezes PC/IF/ID/EX and EX/MEM
//   wen_out ..         MEM/WB inputs (latched every cycle)
//   misalign_out       one-cycle pulse: misaligned access dropped
//   bus_err_out        one-cycle pulse: access aborted on timeout
module mem_access_stage #(
  parameter int DSIZE   = 32,
  parameter int ASIZE   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic [1:0]       size_in,
  input  logic             unsigned_in,
  input  logic             wen_in,
  input  logic             mem_to_reg_in,
  input  logic [DSIZE-1:0] result_in,
  input  logic [DSIZE-1:0] wdata_in,
  input  logic [ASIZE-1:0] waddr_in,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [DSIZE-1:0] dmem_addr,
  output logic [DSIZE-1:0] dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic             dmem_ready,
  input  logic [DSIZE-1:0] dmem_rdata,
  output logic             stall_out,
  output logic             wen_out,
  output logic             mem_to_reg_out,
  output logic [DSIZE-1:0] result_out,
  output logic [DSIZE-1:0] rdata_mem_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             misalign_out,
  output logic             bus_err_out
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            misalign_q;
  logic            bus_err_q;

  logic            is_byte;
  logic            is_half;
  logic            mem_op;
  logic            misal;
  logic            done;
  logic [3:0]      be_st;
  logic [DSIZE-1:0] lane_b;
  logic [DSIZE-1:0] lane_h;
  logic [DSIZE-1:0] load_ext;

  assign is_byte = (size_in == 2'b00);
  assign is_half = (size_in == 2'b01);
  assign mem_op  = valid_in & (mem_read_in | mem_write_in);
  assign misal   = (is_half & result_in[0])
                 | (~is_byte & ~is_half & (|result_in[1:0]));

  // Byte lanes / store replication
  always_comb begin
    be_st      = 4'b1111;
    dmem_wdata = wdata_in;
    unique case (1'b1)
      is_byte: begin
        be_st      = 4'b0001 << result_in[1:0];
        dmem_wdata = {4{wdata_in[7:0]}};
      end
      is_half: begin
        be_st      = 4'b0011 << {result_in[1], 1'b0};
        dmem_wdata = {2{wdata_in[15:0]}};
      end
      default: begin
        be_st      = 4'b1111;
        dmem_wdata = wdata_in;
      end
    endcase
  end

  assign dmem_be   = mem_write_in ? be_st : 4'b0000;
  assign dmem_addr = {result_in[DSIZE-1:2], 2'b00};

  // Load lane select and extension
  assign lane_b = dmem_rdata >> {result_in[1:0], 3'b000};
  assign lane_h = dmem_rdata >> {result_in[1], 4'b0000};

  always_comb begin
    load_ext = dmem_rdata;
    unique case (1'b1)
      is_byte:
        load_ext = {{(DSIZE-8){~unsigned_in & lane_b[7]}},
                    lane_b[7:0]};
      is_half:
        load_ext = {{(DSIZE-16){~unsigned_in & lane_h[15]}},
                    lane_h[15:0]};
      default:
        load_ext = dmem_rdata;
    endcase
  end

  assign rdata_mem_out = load_ext;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= (state_q == IDLE) & mem_op & misal;
      bus_err_q  <= (state_q == BUSY) & (state_d == ABORT);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_op & ~misal & ~dmem_ready) begin
          state_d = BUSY;
          cnt_d   = CW'(1);
        end
      end
      BUSY: begin
        if (dmem_ready)
          state_d = IDLE;
        else if (cnt_q == CW'(TIMEOUT))
          state_d = ABORT;
        else
          cnt_d = cnt_q + CW'(1);
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; reset overrides everything, even mid-access
  always_comb begin
    dmem_req  = 1'b0;
    stall_out = 1'b0;
    done      = 1'b0;
    wen_out   = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (mem_op & ~misal) begin
            dmem_req  = 1'b1;
            done      = dmem_ready;
            stall_out = ~dmem_ready;
          end else if (valid_in & ~mem_op) begin
            wen_out = wen_in;
          end
        end
        BUSY: begin
          dmem_req  = 1'b1;
          done      = dmem_ready;
          stall_out = ~dmem_ready;
        end
        default: begin
          dmem_req = 1'b0;
        end
      endcase
      if (done)
        wen_out = wen_in & ~mem_write_in;
    end
  end

  assign dmem_we        = dmem_req & mem_write_in;
  assign mem_to_reg_out = mem_to_reg_in;
  assign result_out     = result_in;
  assign waddr_out      = waddr_in;
  assign misalign_out   = misalign_q;
  assign bus_err_out    = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes the expected
// per-cycle response, a monitor pops and compares on the falling edge.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, mem_read_in, mem_write_in;
  logic [1:0]  size_in;
  logic        unsigned_in, wen_in, mem_to_reg_in;
  logic [31:0] result_in, wdata_in;
  logic [4:0]  waddr_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall_out, wen_out, mem_to_reg_out;
  logic [31:0] result_out, rdata_mem_out;
  logic [4:0]  waddr_out;
  logic        misalign_out, bus_err_out;

  always #5 clk = ~clk;

  mem_access_stage #(.DSIZE(32), .ASIZE(5), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .size_in(size_in),
    .unsigned_in(unsigned_in), .wen_in(wen_in),
    .mem_to_reg_in(mem_to_reg_in), .result_in(result_in),
    .wdata_in(wdata_in), .waddr_in(waddr_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall_out(stall_out), .wen_out(wen_out),
    .mem_to_reg_out(mem_to_reg_out), .result_out(result_out),
    .rdata_mem_out(rdata_mem_out), .waddr_out(waddr_out),
    .misalign_out(misalign_out), .bus_err_out(bus_err_out)
  );

  typedef struct {
    logic        req, stall, wen, mis, berr, cd, we;
    logic [31:0] addr, wdata, rdata, result;
    logic [3:0]  be;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] ex);
    n_chk++;
    if (act === ex) n_pass++;
    else $display("FAIL cyc%0d %s: got %h want %h", cyc, nm, act, ex);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("req",   32'(dmem_req),     32'(e.req));
        chk("stall", 32'(stall_out),    32'(e.stall));
        chk("wen",   32'(wen_out),      32'(e.wen));
        chk("mis",   32'(misalign_out), 32'(e.mis));
        chk("berr",  32'(bus_err_out),  32'(e.berr));
        if (e.cd) begin
          chk("we",     32'(dmem_we),   32'(e.we));
          chk("addr",   dmem_addr,      e.addr);
          chk("wdata",  dmem_wdata,     e.wdata);
          chk("be",     32'(dmem_be),   32'(e.be));
          chk("rdata",  rdata_mem_out,  e.rdata);
          chk("result", result_out,     e.result);
          chk("waddr",  32'(waddr_out), 32'd7);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic v, rd, wr, input logic [1:0] sz,
                    input logic uns, wen, input logic [31:0] res, wd,
                    input logic rdy, input logic [31:0] rdat);
    valid_in      = v;
    mem_read_in   = rd;
    mem_write_in  = wr;
    size_in       = sz;
    unsigned_in   = uns;
    wen_in        = wen;
    mem_to_reg_in = rd;
    result_in     = res;
    wdata_in      = wd;
    waddr_in      = 5'd7;
    dmem_ready    = rdy;
    dmem_rdata    = rdat;
  endtask

  task automatic ex(input logic req, stall, wen, mis, berr);
    exp_t e;
    e = '{req: req, stall: stall, wen: wen, mis: mis, berr: berr,
          cd: 1'b0, we: 1'b0, addr: '0, wdata: '0, rdata: '0,
          result: '0, be: '0};
    q.push_back(e);
  endtask

  task automatic exd(input logic req, stall, wen, mis, berr, we,
                     input logic [31:0] addr, wdata, rdata,
                     input logic [3:0] be, input logic [31:0] res);
    exp_t e;
    e = '{req: req, stall: stall, wen: wen, mis: mis, berr: berr,
          cd: 1'b1, we: we, addr: addr, wdata: wdata, rdata: rdata,
          result: res, be: be};
    q.push_back(e);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    op(0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
    tick;
    // Reset holds request/stall/wen low even with a live load
    op(1, 1, 0, 2'b10, 0, 1, 32'h100, 0, 0, 0);
    ex(0, 0, 0, 0, 0);
    tick;
    rst = 1'b0;
    // ALU pass-through
    op(1, 0, 0, 2'b10, 0, 1, 32'h1234, 0, 0, 0);
    exd(0, 0, 1, 0, 0, 0, 32'h1234, 0, 0, 4'b0000, 32'h1234);
    tick;
    // lb 0x103 zero-wait, sign-extended
    op(1, 1, 0, 2'b00, 0, 1, 32'h103, 0, 1, 32'h80FF_1122);
    exd(1, 0, 1, 0, 0, 0, 32'h100, 0, 32'hFFFF_FF80, 4'b0000, 32'h103);
    // sh 0x202, three wait cycles
    for (int i = 0; i < 3; i++) begin
      tick;
      op(1, 0, 1, 2'b01, 0, 1, 32'h202, 32'hABCD, 0, 0);
      exd(1, 1, 0, 0, 0, 1, 32'h200, 32'hABCD_ABCD, 0, 4'b1100,
          32'h202);
    end
    tick;
    op(1, 0, 1, 2'b01, 0, 1, 32'h202, 32'hABCD, 1, 0);
    exd(1, 0, 0, 0, 0, 1, 32'h200, 32'hABCD_ABCD, 0, 4'b1100, 32'h202);
    tick;
    // sb 0x011
    op(1, 0, 1, 2'b00, 0, 0, 32'h011, 32'h1234_56A5, 1, 0);
    exd(1, 0, 0, 0, 0, 1, 32'h010, 32'hA5A5_A5A5, 0, 4'b0010, 32'h011);
    tick;
    // lw 0x006 misaligned; ready is ignored without a request
    op(1, 1, 0, 2'b10, 0, 1, 32'h006, 0, 1, 0);
    exd(0, 0, 0, 0, 0, 0, 32'h004, 0, 0, 4'b0000, 32'h006);
    tick;
    // lhu 0x006, misalign pulse from previous cycle
    op(1, 1, 0, 2'b01, 1, 1, 32'h006, 0, 1, 32'hF00D_0000);
    exd(1, 0, 1, 1, 0, 0, 32'h004, 0, 32'h0000_F00D, 4'b0000, 32'h006);
    tick;
    // lh 0x002 signed
    op(1, 1, 0, 2'b01, 0, 1, 32'h002, 0, 1, 32'h8001_0000);
    exd(1, 0, 1, 0, 0, 0, 32'h000, 0, 32'hFFFF_8001, 4'b0000, 32'h002);
    tick;
    // lbu 0x001
    op(1, 1, 0, 2'b00, 1, 1, 32'h001, 0, 1, 32'h0000_9900);
    exd(1, 0, 1, 0, 0, 0, 32'h000, 0, 32'h0000_0099, 4'b0000, 32'h001);
    tick;
    // sw 0x00A misaligned, then idle with stray ready
    op(1, 0, 1, 2'b10, 0, 0, 32'h00A, 32'h5555_5555, 0, 0);
    ex(0, 0, 0, 0, 0);
    tick;
    op(0, 0, 0, 2'b10, 0, 1, 0, 0, 1, 0);
    ex(0, 0, 0, 1, 0);
    // lw 0x300 never ready: 5 request cycles then abort
    for (int i = 0; i < 5; i++) begin
      tick;
      op(1, 1, 0, 2'b10, 0, 1, 32'h300, 0, 0, 0);
      ex(1, 1, 0, 0, 0);
    end
    tick;
    ex(0, 0, 0, 0, 1);
    tick;
    op(1, 1, 0, 2'b10, 0, 1, 32'h300, 0, 1, 32'h1234_5678);
    exd(1, 0, 1, 0, 0, 0, 32'h300, 0, 32'h1234_5678, 4'b0000, 32'h300);
    // Reset in second BUSY cycle abandons the access
    for (int i = 0; i < 2; i++) begin
      tick;
      op(1, 1, 0, 2'b10, 0, 1, 32'h400, 0, 0, 0);
      ex(1, 1, 0, 0, 0);
    end
    tick;
    rst = 1'b1;
    ex(0, 0, 0, 0, 0);
    tick;
    rst = 1'b0;
    // Fresh lw gets the full timeout budget from a cleared counter
    for (int i = 0; i < 5; i++) begin
      ex(1, 1, 0, 0, 0);
      tick;
    end
    ex(0, 0, 0, 0, 1);
    tick;
    op(1, 1, 0, 2'b10, 0, 1, 32'h400, 0, 1, 32'hCAFE_0001);
    exd(1, 0, 1, 0, 0, 0, 32'h400, 0, 32'hCAFE_0001, 4'b0000, 32'h400);
    tick;
    op(0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
    ex(0, 0, 0, 0, 0);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #2;
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
